tetris_piece_slot_writer: RTL

//  Bus master for the block-sprite core's video-slot write port.

---
 rtl/tetris_piece_slot_writer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/tetris_piece_slot_writer.sv
// Slot-bus master: turns one tetromino command into the color and xy/bypass writes for its
// four block slots. Define VSYNC_ALIGN_EN to hold the writes until the next frame_start pulse.
module tetris_piece_slot_writer #(
  parameter int X0       = 240,
  parameter int Y0       = 80,
  parameter int BLOCK_PX = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        hide,
  input  logic [2:0]  piece_type,
  input  logic [1:0]  rot,
  input  logic [3:0]  col,
  input  logic [4:0]  row,
  input  logic [3:0]  slot_base,
  input  logic        frame_start,
  output logic        cs,
  output logic        write,
  output logic [13:0] addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef VSYNC_ALIGN_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_VB, S_COLOR, S_XY, S_FIN} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COLOR, S_XY, S_FIN} state_t;
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
`endif

  state_t      state_q, state_d;
  logic [1:0]  blk_q, blk_d;
  logic        cs_q, cs_d;
  logic [13:0] addr_q, addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [2:0]  type_q;
  logic [1:0]  rot_q;
  logic [3:0]  col_q;
  logic [4:0]  row_q;
  logic [3:0]  base_q;
  logic        hide_q;

  logic        bad_cmd;
  logic        go, wr, wr_color;
  logic [1:0]  wr_blk;
  logic [3:0]  slot;

  // Rotation-0 offset {dx,dy} of block b for piece t.
  function automatic logic [3:0] shape_off(input logic [2:0] t, input logic [1:0] b);
    logic [15:0] s;
    case (t)
      3'd0:    s = 16'b0001_0101_1001_1101;
      3'd1:    s = 16'b0100_1000_0101_1001;
      3'd2:    s = 16'b0100_0001_0101_1001;
      3'd3:    s = 16'b0100_1000_0001_0101;
      3'd4:    s = 16'b0000_0100_0101_1001;
      3'd5:    s = 16'b0000_0001_0101_1001;
      3'd6:    s = 16'b1000_0001_0101_1001;
      default: s = 16'b0;
    endcase
    case (b)
      2'd0:    return s[15:12];
      2'd1:    return s[11:8];
      2'd2:    return s[7:4];
      default: return s[3:0];
    endcase
  endfunction

  function automatic logic [3:0] rot_off(input logic [3:0] o, input logic [1:0] r);
    logic [1:0] dx, dy, t;
    dx = o[3:2];
    dy = o[1:0];
    for (int k = 0; k < 3; k++) begin
      if (2'(k) < r) begin
        t  = dx;
        dx = 2'd3 - dy;
        dy = t;
      end
    end
    return {dx, dy};
  endfunction

  // Screen position wraps modulo 2^11; off-screen pieces are the caller's concern.
  function automatic logic [31:0] xy_word(input logic [3:0] c, input logic [4:0] rw,
                                          input logic [3:0] o, input logic h);
    logic [15:0] x, y;
    x = 16'(X0) + (16'(c) + 16'(o[3:2])) * 16'(BLOCK_PX);
    y = 16'(Y0) + (16'(rw) + 16'(o[1:0])) * 16'(BLOCK_PX);
    return {9'b0, h, y[10:0], x[10:0]};
  endfunction

  assign bad_cmd = (type_q == 3'd7) || (base_q > 4'd11);

  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    busy_d    = busy_q;
    cs_d      = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    go        = 1'b0;
    wr        = 1'b0;
    wr_color  = 1'b0;
    wr_blk    = blk_q;
    slot      = 4'd0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        busy_d  = 1'b1;
      end
      S_LOAD: if (bad_cmd) begin
        state_d = S_FIN;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end else begin
`ifdef VSYNC_ALIGN_EN
        if (frame_start) go = 1'b1;
        else             state_d = S_WAIT_VB;
`else
        go = 1'b1;
`endif
      end
`ifdef VSYNC_ALIGN_EN
      S_WAIT_VB: go = frame_start;
`endif
      S_COLOR: begin
        wr      = 1'b1;
        state_d = S_XY;
      end
      S_XY: if (blk_q == 2'd3) begin
        state_d = S_FIN;
        done_d  = 1'b1;
      end else begin
        wr       = 1'b1;
        wr_blk   = blk_q + 2'd1;
        blk_d    = wr_blk;
        wr_color = !hide_q;
        state_d  = hide_q ? S_XY : S_COLOR;
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (go) begin
      wr       = 1'b1;
      wr_blk   = 2'd0;
      blk_d    = 2'd0;
      wr_color = !hide_q;
      state_d  = hide_q ? S_XY : S_COLOR;
    end

    // The state register names the write now on the bus; this builds the next one.
    if (wr) begin
      cs_d = 1'b1;
      slot = base_q + {2'b00, wr_blk};
      if (wr_color) begin
        addr_d    = 14'h2010 | {10'b0, slot};
        wr_data_d = {29'b0, type_q + 3'd1};
      end else begin
        addr_d    = 14'h2000 | {10'b0, slot};
        wr_data_d = xy_word(col_q, row_q, rot_off(shape_off(type_q, wr_blk), rot_q), hide_q);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      blk_q     <= 2'd0;
      cs_q      <= 1'b0;
      addr_q    <= 14'd0;
      wr_data_q <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      blk_q     <= blk_d;
      cs_q      <= cs_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Command fields are only consumed after LOAD, so they need no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      type_q <= piece_type;
      rot_q  <= rot;
      col_q  <= col;
      row_q  <= row;
      base_q <= slot_base;
      hide_q <= hide;
    end
  end

  assign cs      = cs_q;
  assign write   = cs_q;
  assign addr    = addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
